mem_access_unit: RTL and testbench
==================================

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 The block SHALL have a single clock and a synchronous, active-low reset, with ports named clk and rst as elsewhere in the pipeline.
REQ-002 The block SHALL have these parameters (name, default, meaning):
- TIMEOUT, 16, maximum number of BUSY cycles spent waiting for dmem_ack.
- Data width is `WIDTH = 32 from defines.v.
REQ-003 The block SHALL have these ports (name, direction, width, meaning):
- clk  in  1  clock
- rst  in  1  sync reset, active low
- valid_in  in  1  an instruction occupies the MEM stage
- regwrite_in, memtoreg_in  in  1 each  control bits from EX2MEM
- memread, memwrite  in  1 each  load / store request
- memsize  in  2  00 byte, 01 half, 10 word (11 treated as word)
- memsigned  in  1  sign-extend loads
- aluout_in  in  32  effective address / ALU result
- writedata_in  in  32  store data
- regaddr_in  in  5  destination register
- regwrite_mem, memtoreg_mem  out  1 each  to MEM2WB
- aluout_mem, readdata_mem  out  32 each  to MEM2WB
- regaddr_mem  out  5  to MEM2WB
- stall_mem  out  1  holds PC, IF2ID, ID2EX and EX2MEM
- misalign_mem, buserr_mem  out  1 each  exception flags, valid when stall_mem=0
- dmem_req, dmem_we  out  1 each  bus request, write enable
- dmem_addr  out  32  word-aligned address ({aluout_in[31:2],2'b00})
- dmem_wdata  out  32  lane-replicated store data
- dmem_be  out  4  byte enables
- dmem_rdata  in  32  read data, valid with dmem_ack
- dmem_ack  in  1  one-cycle completion strobe

Function
REQ-004 The block SHALL implement FSM states IDLE, BUSY and DONE.
REQ-005 access = valid_in & (memread|memwrite) & aligned; aligned = word: addr[1:0]==0, half: addr[0]==0, byte: always.
REQ-006 IDLE with access: stall_mem=1; next edge SHALL register dmem_req=1, dmem_we=memwrite, dmem_addr, dmem_be, dmem_wdata; counter cleared; go BUSY.
REQ-007 BUSY: stall_mem=1; all dmem_* outputs SHALL be held stable until dmem_ack; counter increments each BUSY cycle without ack.
REQ-008 BUSY with dmem_ack: next edge SHALL set dmem_req=0, latch formatted read data into readdata_mem (loads only; stores leave it unchanged), and go DONE.
REQ-009 BUSY with counter==TIMEOUT-1 and no ack: next edge SHALL set dmem_req=0, set a buserr flag and go DONE; a late ack SHALL be ignored.
REQ-010 DONE: stall_mem=0; next edge SHALL go IDLE unconditionally; the flag SHALL be cleared on leaving DONE.
REQ-011 A successful access SHALL complete in 3 + (wait cycles before ack) cycles; with ack in the first BUSY cycle, stall_mem SHALL be high for exactly 2 cycles.
REQ-012 Non-memory instructions or valid_in=0 in IDLE: stall_mem=0 and no bus activity.
REQ-013 Misaligned request in IDLE: no bus transaction; stall_mem=0; misalign_mem=1 in that cycle (combinational).
REQ-014 Byte lanes SHALL be little-endian: byte lane n = addr[1:0]; be = 0001<<n for bytes, 0011 or 1100 for halves, 1111 for words.
REQ-015 Store data SHALL be replicated: byte {4{wd[7:0]}}, half {2{wd[15:0]}}, word as-is.
REQ-016 Loads SHALL extract the selected lane and zero-extend, or sign-extend when memsigned=1.
REQ-017 regwrite_mem SHALL equal regwrite_in & valid_in & ~stall_mem & ~misalign_mem & ~buserr_mem.
REQ-018 memtoreg_mem, aluout_mem and regaddr_mem SHALL pass through combinationally from their inputs.
REQ-019 buserr_mem SHALL be 1 only in the DONE cycle following a timeout.

Reset
REQ-020 On rst=0 at a clock edge: state=IDLE, dmem_req=0, dmem_we=0, dmem_be=0, dmem_addr=0, dmem_wdata=0, readdata_mem=0, counter=0, buserr flag=0.
REQ-021 Reset in BUSY SHALL drop dmem_req on that edge; any ack arriving afterwards SHALL be ignored.

Verification
REQ-022 lw addr=0x100, ack in the 2nd BUSY cycle, rdata=0xDEADBEEF -> stall high 3 cycles; DONE: readdata_mem=0xDEADBEEF, regwrite_mem=1.
REQ-023 lb addr=0x103, memsigned=1, rdata=0x80FFFFFF -> be=1000, readdata_mem=0xFFFFFF80; lbu gives 0x00000080.
REQ-024 sh addr=0x102, wd=0x0000ABCD -> dmem_we=1, be=1100, wdata=0xABCDABCD, stable until ack, readdata_mem unchanged.
REQ-025 lw addr=0x101 -> misalign_mem=1, dmem_req stays 0, stall_mem=0, regwrite_mem=0.
REQ-026 lw with no ack -> req held 16 BUSY cycles, then req=0, buserr_mem=1 for one cycle, regwrite_mem=0; an ack one cycle later is ignored.
REQ-027 rst=0 in the 2nd BUSY cycle -> next edge req=0, state IDLE, readdata_mem=0.

Source files
------------

// File: rtl/mem_access_unit.sv
// MEM stage data-bus access unit: aligns, issues and completes loads/stores,
// stalling the pipeline while the bus transaction is outstanding.
`timescale 1ns/1ps
module mem_access_unit #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_in,
  input  logic        regwrite_in,
  input  logic        memtoreg_in,
  input  logic        memread,
  input  logic        memwrite,
  input  logic [1:0]  memsize,
  input  logic        memsigned,
  input  logic [31:0] aluout_in,
  input  logic [31:0] writedata_in,
  input  logic [4:0]  regaddr_in,
  output logic        regwrite_mem,
  output logic        memtoreg_mem,
  output logic [31:0] aluout_mem,
  output logic [31:0] readdata_mem,
  output logic [4:0]  regaddr_mem,
  output logic        stall_mem,
  output logic        misalign_mem,
  output logic        buserr_mem,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  state_e          state_q, state_d;
  logic            req_q, req_d;
  logic            we_q, we_d;
  logic [31:0]     addr_q, addr_d;
  logic [3:0]      be_q, be_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [31:0]     rdata_q, rdata_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            berr_q, berr_d;
  logic [1:0]      lane_q, lane_d;
  logic [1:0]      size_q, size_d;
  logic            sgn_q, sgn_d;
  logic            load_q, load_d;

  logic            aligned;
  logic            access;
  logic [3:0]      be_new;
  logic [31:0]     wdata_new;
  logic [31:0]     sh;
  logic [31:0]     fmt;

  always_comb begin
    aligned   = 1'b1;
    be_new    = 4'b1111;
    wdata_new = writedata_in;
    case (memsize)
      2'b00: begin
        aligned   = 1'b1;
        be_new    = 4'b0001 << aluout_in[1:0];
        wdata_new = {4{writedata_in[7:0]}};
      end
      2'b01: begin
        aligned   = ~aluout_in[0];
        be_new    = aluout_in[1] ? 4'b1100 : 4'b0011;
        wdata_new = {2{writedata_in[15:0]}};
      end
      default: begin
        aligned   = (aluout_in[1:0] == 2'b00);
        be_new    = 4'b1111;
        wdata_new = writedata_in;
      end
    endcase
  end

  assign access       = valid_in & (memread | memwrite) & aligned;
  assign misalign_mem = valid_in & (memread | memwrite) & ~aligned;

  // Lane extraction uses the size/lane captured at issue, not live inputs.
  always_comb begin
    sh  = dmem_rdata >> {lane_q, 3'b000};
    fmt = dmem_rdata;
    case (size_q)
      2'b00: fmt = sgn_q ? {{24{sh[7]}}, sh[7:0]}
                         : {24'h0, sh[7:0]};
      2'b01: fmt = sgn_q ? {{16{sh[15]}}, sh[15:0]}
                         : {16'h0, sh[15:0]};
      default: fmt = dmem_rdata;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    we_d      = we_q;
    addr_d    = addr_q;
    be_d      = be_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    cnt_d     = cnt_q;
    berr_d    = berr_q;
    lane_d    = lane_q;
    size_d    = size_q;
    sgn_d     = sgn_q;
    load_d    = load_q;
    stall_mem = 1'b0;
    case (state_q)
      IDLE: begin
        if (access) begin
          stall_mem = 1'b1;
          req_d     = 1'b1;
          we_d      = memwrite;
          addr_d    = {aluout_in[31:2], 2'b00};
          be_d      = be_new;
          wdata_d   = wdata_new;
          cnt_d     = '0;
          lane_d    = aluout_in[1:0];
          size_d    = memsize;
          sgn_d     = memsigned;
          load_d    = memread & ~memwrite;
          state_d   = BUSY;
        end
      end
      BUSY: begin
        stall_mem = 1'b1;
        if (dmem_ack) begin
          req_d   = 1'b0;
          state_d = DONE;
          if (load_q) rdata_d = fmt;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          req_d   = 1'b0;
          berr_d  = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        berr_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      cnt_q   <= '0;
      berr_q  <= 1'b0;
      lane_q  <= '0;
      size_q  <= '0;
      sgn_q   <= 1'b0;
      load_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
      berr_q  <= berr_d;
      lane_q  <= lane_d;
      size_q  <= size_d;
      sgn_q   <= sgn_d;
      load_q  <= load_d;
    end
  end

  assign dmem_req     = req_q;
  assign dmem_we      = we_q;
  assign dmem_addr    = addr_q;
  assign dmem_be      = be_q;
  assign dmem_wdata   = wdata_q;
  assign readdata_mem = rdata_q;
  assign buserr_mem   = berr_q;

  assign regwrite_mem = regwrite_in & valid_in & ~stall_mem
                      & ~misalign_mem & ~buserr_mem;
  assign memtoreg_mem = memtoreg_in;
  assign aluout_mem   = aluout_in;
  assign regaddr_mem  = regaddr_in;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: loads, stores, misalign,
// bus timeout and reset during an outstanding access.
`timescale 1ns/1ps
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_in, regwrite_in, memtoreg_in;
  logic        memread, memwrite, memsigned;
  logic [1:0]  memsize;
  logic [31:0] aluout_in, writedata_in;
  logic [4:0]  regaddr_in;
  logic        regwrite_mem, memtoreg_mem;
  logic [31:0] aluout_mem, readdata_mem;
  logic [4:0]  regaddr_mem;
  logic        stall_mem, misalign_mem, buserr_mem;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_rdata;
  logic        dmem_ack;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_access_unit #(.TIMEOUT(16)) dut (
    .clk(clk), .rst(rst),
    .valid_in(valid_in), .regwrite_in(regwrite_in),
    .memtoreg_in(memtoreg_in),
    .memread(memread), .memwrite(memwrite),
    .memsize(memsize), .memsigned(memsigned),
    .aluout_in(aluout_in), .writedata_in(writedata_in),
    .regaddr_in(regaddr_in),
    .regwrite_mem(regwrite_mem), .memtoreg_mem(memtoreg_mem),
    .aluout_mem(aluout_mem), .readdata_mem(readdata_mem),
    .regaddr_mem(regaddr_mem),
    .stall_mem(stall_mem), .misalign_mem(misalign_mem),
    .buserr_mem(buserr_mem),
    .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_be(dmem_be), .dmem_rdata(dmem_rdata),
    .dmem_ack(dmem_ack)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one edge, let state settle, then inputs may change.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle_in();
    valid_in = 0; regwrite_in = 0; memtoreg_in = 0;
    memread = 0; memwrite = 0; memsize = 2'b10;
    memsigned = 0; aluout_in = 0; writedata_in = 0;
    regaddr_in = 0; dmem_rdata = 0; dmem_ack = 0;
  endtask

  task automatic lb(input logic [31:0] a, input logic s);
    valid_in = 1; memread = 1; memwrite = 0;
    memsize = 2'b00; memsigned = s; aluout_in = a;
    regwrite_in = 1;
    settle();
    chk("lb_idle_stall", stall_mem, 1);
    cyc();
    chk("lb_be", dmem_be, 4'b1000);
    chk("lb_addr", dmem_addr, 32'h100);
    chk("lb_b1_stall", stall_mem, 1);
    dmem_ack = 1; dmem_rdata = 32'h80FFFFFF;
    cyc();
    dmem_ack = 0;
    settle();
    chk("lb_done_stall", stall_mem, 0);
    chk("lb_data", readdata_mem, s ? 32'hFFFFFF80 : 32'h00000080);
    valid_in = 0;
    cyc();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 0;
    idle_in();
    cyc();
    cyc();
    chk("rst_req", dmem_req, 0);
    chk("rst_we", dmem_we, 0);
    chk("rst_be", dmem_be, 0);
    chk("rst_addr", dmem_addr, 0);
    chk("rst_wdata", dmem_wdata, 0);
    chk("rst_rdata", readdata_mem, 0);
    chk("rst_stall", stall_mem, 0);
    chk("rst_berr", buserr_mem, 0);
    rst = 1;
    cyc();

    // Non-memory instruction flows through without stalling.
    valid_in = 1; regwrite_in = 1; memtoreg_in = 1;
    aluout_in = 32'h1234_5678; regaddr_in = 5'd9;
    settle();
    chk("alu_stall", stall_mem, 0);
    chk("alu_regwrite", regwrite_mem, 1);
    chk("alu_pass", aluout_mem, 32'h1234_5678);
    chk("alu_regaddr", regaddr_mem, 5'd9);
    chk("alu_memtoreg", memtoreg_mem, 1);
    cyc();
    chk("alu_noreq", dmem_req, 0);

    // lw 0x100, ack on 2nd BUSY cycle.
    memread = 1; memsize = 2'b10; aluout_in = 32'h100;
    regaddr_in = 5'd5;
    settle();
    chk("lw_idle_stall", stall_mem, 1);
    chk("lw_idle_rw", regwrite_mem, 0);
    cyc();
    chk("lw_b1_req", dmem_req, 1);
    chk("lw_b1_we", dmem_we, 0);
    chk("lw_b1_addr", dmem_addr, 32'h100);
    chk("lw_b1_be", dmem_be, 4'b1111);
    chk("lw_b1_stall", stall_mem, 1);
    cyc();
    dmem_ack = 1; dmem_rdata = 32'hDEADBEEF;
    settle();
    chk("lw_b2_stall", stall_mem, 1);
    chk("lw_b2_req", dmem_req, 1);
    cyc();
    dmem_ack = 0;
    settle();
    chk("lw_done_stall", stall_mem, 0);
    chk("lw_done_data", readdata_mem, 32'hDEADBEEF);
    chk("lw_done_rw", regwrite_mem, 1);
    chk("lw_done_req", dmem_req, 0);
    valid_in = 0; memread = 0;
    cyc();
    chk("lw_idle_after", stall_mem, 0);

    lb(32'h103, 1'b1);
    lb(32'h103, 1'b0);

    // sh 0x102: store data must stay registered while waiting.
    valid_in = 1; memread = 0; memwrite = 1;
    memsize = 2'b01; aluout_in = 32'h102;
    writedata_in = 32'h0000ABCD; regwrite_in = 0;
    settle();
    chk("sh_idle_stall", stall_mem, 1);
    cyc();
    chk("sh_we", dmem_we, 1);
    chk("sh_be", dmem_be, 4'b1100);
    chk("sh_wdata", dmem_wdata, 32'hABCDABCD);
    writedata_in = 32'h12345678;
    cyc();
    chk("sh_hold_wdata", dmem_wdata, 32'hABCDABCD);
    chk("sh_hold_be", dmem_be, 4'b1100);
    chk("sh_hold_req", dmem_req, 1);
    dmem_ack = 1; dmem_rdata = 32'h11111111;
    cyc();
    dmem_ack = 0;
    settle();
    chk("sh_rdata_kept", readdata_mem, 32'h00000080);
    chk("sh_done_req", dmem_req, 0);
    valid_in = 0; memwrite = 0;
    cyc();

    // lw 0x101 is misaligned.
    valid_in = 1; memread = 1; memsize = 2'b10;
    aluout_in = 32'h101; regwrite_in = 1;
    settle();
    chk("mis_flag", misalign_mem, 1);
    chk("mis_stall", stall_mem, 0);
    chk("mis_rw", regwrite_mem, 0);
    cyc();
    chk("mis_noreq", dmem_req, 0);
    valid_in = 0;
    settle();
    chk("mis_clear", misalign_mem, 0);
    cyc();

    // lw with no ack: timeout after 16 BUSY cycles.
    valid_in = 1; memread = 1; aluout_in = 32'h200;
    regwrite_in = 1;
    cyc();
    for (int i = 0; i < 16; i++) begin
      chk("to_req", dmem_req, 1);
      chk("to_stall", stall_mem, 1);
      cyc();
    end
    chk("to_done_req", dmem_req, 0);
    chk("to_berr", buserr_mem, 1);
    chk("to_rw", regwrite_mem, 0);
    chk("to_stall_done", stall_mem, 0);
    valid_in = 0;
    dmem_ack = 1; dmem_rdata = 32'h55555555;
    cyc();
    dmem_ack = 0;
    settle();
    chk("to_berr_clr", buserr_mem, 0);
    chk("to_late_req", dmem_req, 0);
    chk("to_late_data", readdata_mem, 32'h00000080);
    cyc();
    chk("to_late_stall", stall_mem, 0);

    // Reset during the 2nd BUSY cycle.
    valid_in = 1; memread = 1; aluout_in = 32'h300;
    cyc();
    chk("rb_b1_req", dmem_req, 1);
    cyc();
    rst = 0;
    cyc();
    rst = 1; valid_in = 0; memread = 0;
    dmem_ack = 1; dmem_rdata = 32'hCAFEF00D;
    settle();
    chk("rb_req", dmem_req, 0);
    chk("rb_rdata", readdata_mem, 0);
    chk("rb_stall", stall_mem, 0);
    cyc();
    dmem_ack = 0;
    settle();
    chk("rb_req2", dmem_req, 0);
    chk("rb_rdata2", readdata_mem, 0);
    chk("rb_berr", buserr_mem, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
